seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_pkg.sv | 28 ++
 rtl/seq_tx_shifter.sv | 41 ++++
 rtl/seq_tx.sv | 125 ++++++++++++
 tb/tb_seq_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_pkg
// Purpose  : Shared state encoding, frame flag and run-length helper for seq_tx.
// Revision : 1.0  initial release
// ============================================================================
package seq_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLAG   = 3'd1,
        ST_DATA   = 3'd2,
        ST_STUFF  = 3'd3
`ifdef SEQ_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    localparam logic [3:0] C_FLAG_BITS = 4'b1110;
    localparam int         C_FLAG_LEN  = 4;
    localparam logic [1:0] C_RUN_MAX   = 2'd2;

    function automatic logic [1:0] next_run(input logic [1:0] run, input logic b);
        return b ? run + 2'd1 : 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_shifter
// Purpose  : Payload shift register (MSB first) with emitted-bit index.
// Revision : 1.0  initial release
// ============================================================================
module seq_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb,
    output logic              empty
);

    localparam int C_IDX_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  r_sreg;
    logic [C_IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (load) begin
            r_sreg <= load_data;
            r_idx  <= '0;
        end else if (shift) begin
            r_sreg <= {r_sreg[DATA_W-2:0], 1'b0};
            r_idx  <= r_idx + C_IDX_W'(1);
        end
    end

    assign msb   = r_sreg[DATA_W-1];
    assign empty = (r_idx == C_IDX_W'(DATA_W));

endmodule
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx
// Purpose  : Serial frame transmitter: flag 1110, bit-stuffed payload, optional
//            even parity (enabled by defining SEQ_TX_PARITY_EN).
// Revision : 1.0  initial release
// ============================================================================
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              out,
    output logic              busy,
    output logic              done
);

    state_t                  r_state;
    logic [C_FLAG_LEN-2:0]   r_flag_sr;
    logic [2:0]              r_flag_left;
    logic [1:0]              r_run;
    logic                    r_out;
    logic                    r_busy;
    logic                    r_done;
`ifdef SEQ_TX_PARITY_EN
    logic                    r_par;
    logic                    r_par_sent;
`endif

    logic w_load;
    logic w_shift;
    logic w_flag_active;
    logic w_field;
    logic w_sh_msb;
    logic w_sh_empty;

    // w_field: this edge emits a field bit (payload/parity) or ends the frame
    // rather than a flag bit or a stuffed zero.
    assign w_flag_active = (r_state == ST_FLAG) && (r_flag_left != 3'd0);
    assign w_field       = (r_state != ST_IDLE) && !w_flag_active && (r_run != C_RUN_MAX);
    assign w_load        = (r_state == ST_IDLE) && start;
    assign w_shift       = w_field && !w_sh_empty;

    seq_tx_shifter #(
        .DATA_W    (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .shift     (w_shift),
        .load_data (data),
        .msb       (w_sh_msb),
        .empty     (w_sh_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_flag_sr   <= '0;
            r_flag_left <= '0;
            r_run       <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            r_par       <= 1'b0;
            r_par_sent  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_out <= 1'b0;
                if (start) begin
                    r_state     <= ST_FLAG;
                    r_out       <= C_FLAG_BITS[C_FLAG_LEN-1];
                    r_busy      <= 1'b1;
                    r_flag_sr   <= C_FLAG_BITS[C_FLAG_LEN-2:0];
                    r_flag_left <= 3'(C_FLAG_LEN - 1);
                    r_run       <= 2'd0;
`ifdef SEQ_TX_PARITY_EN
                    r_par       <= ^data;
                    r_par_sent  <= 1'b0;
`endif
                end
            end else if (w_flag_active) begin
                r_out       <= r_flag_sr[C_FLAG_LEN-2];
                r_flag_sr   <= {r_flag_sr[C_FLAG_LEN-3:0], 1'b0};
                r_flag_left <= r_flag_left - 3'd1;
            end else if (!w_field) begin
                r_out   <= 1'b0;
                r_run   <= 2'd0;
                r_state <= ST_STUFF;
            end else if (!w_sh_empty) begin
                r_out   <= w_sh_msb;
                r_run   <= next_run(r_run, w_sh_msb);
                r_state <= ST_DATA;
            end
`ifdef SEQ_TX_PARITY_EN
            else if (!r_par_sent) begin
                r_out      <= r_par;
                r_run      <= next_run(r_run, r_par);
                r_par_sent <= 1'b1;
                r_state    <= ST_PARITY;
            end
`endif
            else begin
                r_out   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_run   <= 2'd0;
                r_state <= ST_IDLE;
            end
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_tx
// Purpose  : Self-checking bench for seq_tx using an expected-bit scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_tx;

    localparam int DATA_W = 8;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data  = '0;
    logic              out;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    seq_tx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference frame: flag, then each field bit followed by a 0 after any run of two 1s.
    function automatic void push_model(input logic [DATA_W-1:0] d);
        int   run = 0;
        logic b;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b = d[i];
            exp_q.push_back(b);
            run = b ? run + 1 : 0;
            if (run == 2) begin
                exp_q.push_back(1'b0);
                run = 0;
            end
        end
`ifdef SEQ_TX_PARITY_EN
        b = ^d;
        exp_q.push_back(b);
        run = b ? run + 1 : 0;
        if (run == 2) exp_q.push_back(1'b0);
`endif
    endfunction

    function automatic void push_const(input logic [15:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endfunction

    // Drives one frame and checks every bit popped from the scoreboard.
    task automatic run_frame(input logic [DATA_W-1:0] d, input bit hold, input int pulse_at);
        int n        = 0;
        int ones     = 0;
        int max_ones = 0;
        bit e;
        start = 1'b1;
        data  = d;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        data = ~d;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (out !== e || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL frame_bit%0d data=%h: out=%b busy=%b done=%b, want out=%b busy=1 done=0",
                         n, d, out, busy, done, e);
            end
            ones = (out === 1'b1) ? ones + 1 : 0;
            if (n >= 4 && ones > max_ones) max_ones = ones;
            n++;
            if (n == pulse_at) start = 1'b1;
            else if (n == pulse_at + 1 && !hold) start = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0) begin
            bad++;
            $display("FAIL frame_end data=%h: out=%b busy=%b done=%b, want out=0 busy=0 done=1",
                     d, out, busy, done);
        end
        total++;
        if (max_ones >= 3) begin
            bad++;
            $display("FAIL three_ones data=%h: field run=%0d, want <3", d, max_ones);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        #2;
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: out=%b busy=%b done=%b, want 0 0 0", out, busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: out=%b busy=%b done=%b, want 0 0 0", out, busy, done);
        end
        start = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: out=%b busy=%b done=%b, want 0 0 0", out, busy, done);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] v;
        v = 16'h0E00;
        push_const(v, 12);
        run_frame(8'h00, 1'b0, -1);
        v = 16'hEDB6;
        push_const(v, 16);
        run_frame(8'hFF, 1'b0, -1);
`ifdef SEQ_TX_PARITY_EN
        v = 16'h7596;
        push_const(v, 15);
`else
        v = 16'h1D65;
        push_const(v, 13);
`endif
        run_frame(8'hB5, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        push_model(8'h3C);
        run_frame(8'h3C, 1'b0, 3);
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_idle: out=%b busy=%b done=%b, want 0 0 0", out, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        push_model(8'hA7);
        run_frame(8'hA7, 1'b1, -1);
        push_model(8'h5E);
        run_frame(8'h5E, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 6; k++) begin
            d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            push_model(d);
            run_frame(d, 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start = 1'b1;
        data  = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || out !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame_busy: out=%b busy=%b, want out=1 busy=1", out, busy);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: out=%b busy=%b done=%b, want 0 0 0", out, busy, done);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        @(negedge clk) reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_no_done: done pulses=%0d, want 0", dones);
        end
        push_model(8'hB5);
        run_frame(8'hB5, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
